zero_detect_scheduler: RTL and testbench
========================================

// Module: zero_detect_scheduler
// PURPOSE
//  Time-shares one Mealy zero-detector among NUM_REQ requesters: accepts a WORD_W-bit word
//  from one requester (round-robin), clears the detector, streams the word MSB-first into it,
//  counts y_out pulses, and returns a per-word result tagged with the requester id.
//  Sits between requester logic and a single MealyZeroDetectorSB instance (det_* ports).
// PARAMETERS
//  NUM_REQ  4                        number of requesters (>=2)
//  WORD_W   8                        bits per submitted word (>=2)
//  ID_W     $clog2(NUM_REQ)          requester id width (derived)
//  CNT_W    $clog2(WORD_W+1)         hit-count width (derived)
// PORTS
//  clock       in   1                 single clock, rising edge
//  reset       in   1                 asynchronous, active-low
//  req_valid   in   NUM_REQ           per-requester word valid
//  req_data    in   NUM_REQ*WORD_W    word of requester i at [i*WORD_W +: WORD_W]
//  req_ready   out  NUM_REQ           one-hot accept strobe
//  det_x_in    out  1                 serial bit to detector x_in (registered)
//  det_reset   out  1                 detector reset, active-low (registered)
//  det_y_out   in   1                 detector Mealy output
//  rsp_valid   out  1                 result valid
//  rsp_ready   in   1                 result consumed
//  rsp_id      out  ID_W              requester of this result
//  rsp_count   out  CNT_W             y_out pulses seen over the word
//  rsp_hit     out  1                 rsp_count != 0
//  busy        out  1                 state != IDLE
// BEHAVIOUR
//  Reset (reset=0): state IDLE, det_reset=0, det_x_in=0, req_ready=0, rsp_*=0, rr pointer=0.
//  FSM IDLE -> CLEAR -> SHIFT -> REPORT -> IDLE.
//  IDLE: det_reset=1. If any req_valid: grant g = first valid at or after pointer (wrapping);
//   req_ready[g]=1 this cycle only; capture req_data[g], id; pointer <= g+1 mod NUM_REQ; ->CLEAR.
//   req_ready is combinational from req_valid in IDLE; all-zero otherwise.
//  CLEAR: det_reset=0 for exactly one cycle, det_x_in=0, count<=0; ->SHIFT, bit_idx=0.
//  SHIFT: det_x_in = word[WORD_W-1-bit_idx]; det_y_out sampled at end of that same cycle
//   (Mealy: reflects current bit); count += det_y_out. After WORD_W bits ->REPORT.
//  REPORT: rsp_valid=1, rsp_* stable until rsp_valid&rsp_ready; then ->IDLE. det_x_in=0.
//  Latency: accept edge to rsp_valid = WORD_W+2 cycles. One word in flight; no bypass:
//   rsp handshake and new req_valid in same cycle -> new grant on the following IDLE cycle.
//  req_valid dropped before grant: no effect. Requester is never granted twice in a row
//   while another requester is valid.
//  count cannot overflow (max WORD_W/2 pulses; CNT_W sized for WORD_W).
//  reset asserted mid-word: abort immediately, no response, all outputs to reset values.
// CONFIGURATION
//  ZD_SCHED_FIRST_IDX_EN defined: extra output rsp_first_idx [CNT_W-1:0] = bit index (0=MSB)
//   of first y_out pulse in the word, WORD_W if none; reset value 0; valid with rsp_valid.
//  Not defined: port and its register absent; all other behaviour identical.
// STRUCTURE
//  Package zd_sched_pkg: state enum {IDLE,CLEAR,SHIFT,REPORT}, state width, helper function
//   for next round-robin index.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer in, one-hot grant + index out, comb.
//  Top holds FSM, shift register, bit counter, hit counter, response registers.
// TESTING (bench instantiates the real detector; y=1 on each 0 that follows a 1 since clear)
//  1 Reset: reset=0 for 5 cycles -> det_reset=0, rsp_valid=0, busy=0; release -> det_reset=1.
//  2 Req0 word 8'b1101_1100 -> id 0, count 2, hit 1, rsp_valid exactly 10 cycles after accept.
//  3 Words 8'h00 and 8'hFF -> count 0, hit 0; 8'hAA -> count 4 (first_idx 1 when _EN set).
//  4 All 4 req_valid held high -> grants 0,1,2,3,0 in order; one req_ready pulse per word.
//  5 rsp_ready low 6 cycles in REPORT -> rsp_* held stable, no new req_ready until consumed.
//  6 reset asserted mid-SHIFT -> no response; next word after release reports correct count.

Source files
------------

// File: rtl/zd_sched_pkg.sv
// zd_sched_pkg
//   Shared types and helpers for zero_detect_scheduler.
//   - state_t : scheduler FSM encoding
//   - rr_next : next round-robin index, wrapping at num_req
package zd_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   ptr, wrapping around.
// Ports
//   req        in   NUM_REQ   request vector
//   ptr        in   ID_W      highest-priority index this cycle
//   grant      out  NUM_REQ   one-hot grant (all zero when no request)
//   grant_idx  out  ID_W      index of the granted request
//   grant_any  out  1         any request granted
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req[j]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/zero_detect_scheduler.sv
// zero_detect_scheduler
//   Time-shares one Mealy zero-detector among NUM_REQ requesters. A word is
//   taken round-robin, the detector is cleared, the word is streamed MSB-first
//   and y pulses are counted; the result is returned tagged with the id.
//   Optional feature macro: ZD_SCHED_FIRST_IDX_EN adds rsp_first_idx
//   (bit index of the first y pulse, WORD_W if none).
// Ports
//   clock, reset        clock (rising), async active-low reset
//   req_valid/req_data  per-requester word offers; req_ready one-hot accept
//   det_x_in/det_reset  registered drive to the detector; det_y_out its output
//   rsp_valid/rsp_ready result handshake; rsp_id, rsp_count, rsp_hit payload
//   busy                FSM not idle
//
// state  | meaning
// IDLE   | detector released, waiting for a request to grant
// CLEAR  | detector held in reset for one cycle, hit counter cleared
// SHIFT  | one word bit loaded toward the detector per cycle
// REPORT | last sample folded in, then response held until consumed
module zero_detect_scheduler
    import zd_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WORD_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      det_x_in,
    output logic                      det_reset,
    input  logic                      det_y_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          rsp_count,
    output logic                      rsp_hit,
`ifdef ZD_SCHED_FIRST_IDX_EN
    output logic [CNT_W-1:0]          rsp_first_idx,
`endif
    output logic                      busy
);

    state_t              state, state_next;
    logic [ID_W-1:0]     ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [WORD_W-1:0]   grant_word;
    logic [WORD_W-1:0]   word_q;
    logic [ID_W-1:0]     id_q;
    logic [CNT_W-1:0]    bit_idx;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic                samp_en;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_word = req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // det_x_in is registered, so the detector sees bit k one cycle after the
    // SHIFT cycle that loaded it; samp_en marks the cycle its y is valid.
    assign count_next = count + CNT_W'(det_y_out);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (grant_any) state_next = CLEAR;
            end
            CLEAR:  state_next = SHIFT;
            SHIFT:  if (bit_idx == CNT_W'(WORD_W - 1)) state_next = REPORT;
            REPORT: if (rsp_valid && rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            word_q    <= '0;
            id_q      <= '0;
            bit_idx   <= '0;
            count     <= '0;
            samp_en   <= 1'b0;
            det_x_in  <= 1'b0;
            det_reset <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
            rsp_hit   <= 1'b0;
        end else begin
            det_reset <= (state != CLEAR);
            det_x_in  <= (state == SHIFT) ? word_q[WORD_W-1] : 1'b0;
            samp_en   <= (state == SHIFT);
            if (samp_en) count <= count_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        word_q <= grant_word;
                        id_q   <= grant_idx;
                        ptr    <= ID_W'(rr_next(32'(grant_idx), NUM_REQ));
                    end
                end
                CLEAR: begin
                    count   <= '0;
                    bit_idx <= '0;
                end
                SHIFT: begin
                    word_q  <= {word_q[WORD_W-2:0], 1'b0};
                    bit_idx <= bit_idx + CNT_W'(1);
                end
                REPORT: begin
                    if (samp_en) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_count <= count_next;
                        rsp_hit   <= (count_next != '0);
                    end else if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ZD_SCHED_FIRST_IDX_EN
    // first_idx == WORD_W doubles as "no pulse seen yet".
    logic [CNT_W-1:0] samp_idx;
    logic [CNT_W-1:0] first_idx;
    logic [CNT_W-1:0] first_idx_next;

    always_comb begin
        first_idx_next = first_idx;
        if (samp_en && det_y_out && (first_idx == CNT_W'(WORD_W))) begin
            first_idx_next = samp_idx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            samp_idx      <= '0;
            first_idx     <= '0;
            rsp_first_idx <= '0;
        end else begin
            samp_idx <= bit_idx;
            if (state == CLEAR) begin
                first_idx <= CNT_W'(WORD_W);
            end else begin
                first_idx <= first_idx_next;
            end
            if (state == REPORT && samp_en) begin
                rsp_first_idx <= first_idx_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_zero_detect_scheduler.sv
module tb_zero_detect_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 8;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*WORD_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      det_x_in;
    logic                      det_reset;
    logic                      det_y_out;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [ID_W-1:0]           rsp_id;
    logic [CNT_W-1:0]          rsp_count;
    logic                      rsp_hit;
    logic                      busy;
`ifdef ZD_SCHED_FIRST_IDX_EN
    logic [CNT_W-1:0]          rsp_first_idx;
`endif

    typedef struct {
        int id;
        int cnt;
        int first;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    zero_detect_scheduler #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_x_in  (det_x_in),
        .det_reset (det_reset),
        .det_y_out (det_y_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_hit   (rsp_hit),
`ifdef ZD_SCHED_FIRST_IDX_EN
        .rsp_first_idx (rsp_first_idx),
`endif
        .busy      (busy)
    );

    // Mealy zero detector: y on each 0 immediately following a 1 since clear.
    logic det_prev;
    always_ff @(posedge clock or negedge det_reset) begin
        if (!det_reset) det_prev <= 1'b0;
        else            det_prev <= det_x_in;
    end
    assign det_y_out = ~det_x_in & det_prev;

    function automatic void model(input logic [WORD_W-1:0] w, output int cnt, output int first);
        logic prev;
        logic b;
        prev  = 1'b0;
        cnt   = 0;
        first = WORD_W;
        for (int i = 0; i < WORD_W; i++) begin
            b = w[WORD_W-1-i];
            if (!b && prev) begin
                cnt++;
                if (first == WORD_W) first = i;
            end
            prev = b;
        end
    endfunction

    task automatic submit(input int r, input logic [WORD_W-1:0] w, output bit ok);
        exp_t e;
        req_data[r*WORD_W +: WORD_W] = w;
        req_valid[r] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock); #1;
            if (req_ready[r]) ok = 1'b1;
        end
        if (ok) begin
            e.id = r;
            model(w, e.cnt, e.first);
            sb.push_back(e);
            @(posedge clock); #1;
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(posedge clock); #1;
            cycles++;
            if (rsp_valid) got = 1'b1;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        n_total++;
        if ({det_reset, det_x_in, rsp_valid, busy, req_ready} !== 8'b0)
            $display("FAIL reset_state det_reset=%0b x=%0b rsp_valid=%0b busy=%0b ready=%b want all 0",
                     det_reset, det_x_in, rsp_valid, busy, req_ready);
        else n_pass++;
        reset = 1'b1;
        @(posedge clock); #1;
        n_total++;
        if (det_reset !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release det_reset=%0b busy=%0b want 1/0", det_reset, busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok, got;
        int cyc;
        exp_t e;
        submit(0, 8'b1101_1100, ok);
        n_total++;
        if (!ok) $display("FAIL basic_grant req_ready[0] never seen"); else n_pass++;
        wait_rsp(40, got, cyc);
        n_total++;
        if (!got || cyc != WORD_W + 2)
            $display("FAIL basic_latency got=%0b after %0d cycles want 10", got, cyc);
        else n_pass++;
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (rsp_id !== ID_W'(e.id) || rsp_count !== CNT_W'(e.cnt) || e.cnt != 2)
                $display("FAIL basic_result id=%0d count=%0d want id 0 count 2 (model %0d)", rsp_id, rsp_count, e.cnt);
            else n_pass++;
            n_total++;
            if (rsp_hit !== 1'b1) $display("FAIL basic_hit hit=%0b want 1", rsp_hit); else n_pass++;
`ifdef ZD_SCHED_FIRST_IDX_EN
            n_total++;
            if (rsp_first_idx !== CNT_W'(e.first))
                $display("FAIL basic_first first_idx=%0d want %0d", rsp_first_idx, e.first);
            else n_pass++;
`endif
            consume();
        end
    endtask

    task automatic test_patterns();
        logic [WORD_W-1:0] words [3];
        bit ok, got;
        int cyc;
        exp_t e;
        words[0] = 8'h00;
        words[1] = 8'hFF;
        words[2] = 8'hAA;
        for (int n = 0; n < 3; n++) begin
            submit(n + 1, words[n], ok);
            wait_rsp(40, got, cyc);
            n_total++;
            if (!ok || !got) $display("FAIL pattern_timeout word=%h ok=%0b got=%0b", words[n], ok, got);
            else n_pass++;
            if (ok && got && sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (rsp_id !== ID_W'(n + 1) || rsp_count !== CNT_W'(e.cnt) || rsp_hit !== (e.cnt != 0))
                    $display("FAIL pattern_result word=%h id=%0d count=%0d hit=%0b want id %0d count %0d",
                             words[n], rsp_id, rsp_count, rsp_hit, n + 1, e.cnt);
                else n_pass++;
`ifdef ZD_SCHED_FIRST_IDX_EN
                n_total++;
                if (rsp_first_idx !== CNT_W'(e.first))
                    $display("FAIL pattern_first word=%h first_idx=%0d want %0d", words[n], rsp_first_idx, e.first);
                else n_pass++;
`endif
                consume();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WORD_W-1:0] words [NUM_REQ];
        bit ok, got;
        int cyc, g;
        exp_t e;
        words[0] = 8'hDC;
        words[1] = 8'h96;
        words[2] = 8'h01;
        words[3] = 8'h80;
        for (int r = 0; r < NUM_REQ; r++) req_data[r*WORD_W +: WORD_W] = words[r];
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            g  = n % NUM_REQ;
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clock); #1;
                if (req_ready != '0) ok = 1'b1;
            end
            n_total++;
            if (req_ready !== NUM_REQ'(1 << g))
                $display("FAIL rr_grant word %0d ready=%b want one-hot %0d", n, req_ready, g);
            else n_pass++;
            if (ok) begin
                e.id = g;
                model(words[g], e.cnt, e.first);
                sb.push_back(e);
                @(posedge clock); #1;
            end
            wait_rsp(40, got, cyc);
            n_total++;
            if (!got || req_ready !== '0)
                $display("FAIL rr_busy word %0d got=%0b ready=%b want rsp and no ready", n, got, req_ready);
            else n_pass++;
            if (got && sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (rsp_id !== ID_W'(e.id) || rsp_count !== CNT_W'(e.cnt))
                    $display("FAIL rr_result word %0d id=%0d count=%0d want %0d/%0d", n, rsp_id, rsp_count, e.id, e.cnt);
                else n_pass++;
                consume();
            end
        end
        req_valid = '0;
    endtask

    task automatic test_stall();
        bit ok, got;
        int cyc;
        exp_t e;
        submit(1, 8'h5A, ok);
        wait_rsp(40, got, cyc);
        n_total++;
        if (!ok || !got) $display("FAIL stall_rsp ok=%0b got=%0b", ok, got); else n_pass++;
        if (ok && got && sb.size() > 0) begin
            e = sb[0];
            req_data[2*WORD_W +: WORD_W] = 8'h3C;
            req_valid[2] = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clock); #1;
                n_total++;
                if ({rsp_valid, rsp_id, rsp_count, rsp_hit, req_ready} !==
                    {1'b1, ID_W'(e.id), CNT_W'(e.cnt), (e.cnt != 0), 4'b0000})
                    $display("FAIL stall_hold cycle %0d valid=%0b id=%0d count=%0d ready=%b want 1/%0d/%0d/0000",
                             i, rsp_valid, rsp_id, rsp_count, req_ready, e.id, e.cnt);
                else n_pass++;
            end
            void'(sb.pop_front());
            consume();
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clock); #1;
                if (req_ready[2]) ok = 1'b1;
            end
            n_total++;
            if (!ok || req_ready !== 4'b0100)
                $display("FAIL stall_next_grant ready=%b want 0100", req_ready);
            else n_pass++;
            if (ok) begin
                e.id = 2;
                model(8'h3C, e.cnt, e.first);
                @(posedge clock); #1;
                req_valid[2] = 1'b0;
                wait_rsp(40, got, cyc);
                n_total++;
                if (!got || rsp_id !== 2'd2 || rsp_count !== CNT_W'(e.cnt))
                    $display("FAIL stall_next_result got=%0b id=%0d count=%0d want 2/%0d", got, rsp_id, rsp_count, e.cnt);
                else n_pass++;
                consume();
            end
            req_valid[2] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok, got, seen;
        int cyc;
        exp_t e;
        submit(0, 8'hDC, ok);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        if (ok && sb.size() > 0) void'(sb.pop_back());
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if ({busy, rsp_valid, det_reset, det_x_in} !== 4'b0)
            $display("FAIL abort_state busy=%0b rsp_valid=%0b det_reset=%0b x=%0b want 0",
                     busy, rsp_valid, det_reset, det_x_in);
        else n_pass++;
        reset = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(posedge clock); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL abort_no_rsp rsp_valid=1 want 0"); else n_pass++;
        submit(0, 8'hAA, ok);
        wait_rsp(40, got, cyc);
        n_total++;
        if (!ok || !got || sb.size() == 0) $display("FAIL abort_next ok=%0b got=%0b", ok, got);
        else begin
            e = sb.pop_front();
            if (rsp_id !== 2'd0 || rsp_count !== CNT_W'(e.cnt) || e.cnt != 4)
                $display("FAIL abort_next id=%0d count=%0d want 0/4", rsp_id, rsp_count);
            else n_pass++;
            consume();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
